// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and PC-unit state encoding.
package rv32i_pkg;

  // Branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // PC unit states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_cond.sv
// Branch condition resolver: maps comparator flags and funct3 to taken/not-taken.
module branch_cond
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  input  logic       work,
  output logic       cond
);

  // The comparator idles with BrEq=BrLT=1, so gate everything on work.
  always_comb begin
    cond = 1'b0;
    if (work) begin
      case (funct3)
        F3_BEQ:           cond = BrEq;
        F3_BNE:           cond = ~BrEq;
        F3_BLT, F3_BLTU:  cond = BrLT;
        F3_BGE, F3_BGEU:  cond = ~BrLT;
        default:          cond = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch resolution and PC ownership: redirect, multi-cycle flush, misaligned-target trap.
module branch_pc_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned FLUSH_LEN = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             instr_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic             BrEq,
  input  logic             BrLT,
  input  logic             work,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1_data,
  input  logic             trap_clr,
  output logic [31:0]      pc,
  output logic [31:0]      link_addr,
  output logic             taken,
  output logic             flush,
  output logic             trap,
  output logic [31:0]      trap_addr,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int unsigned FCW = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);

  pc_state_e       stateQ, stateD;
  logic [31:0]     pcQ, pcD;
  logic            flushQ, flushD;
  logic            trapQ, trapD;
  logic [31:0]     trapAddrQ, trapAddrD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [FCW-1:0]  flushCntQ, flushCntD;

  logic        brCond;
  logic        redirReq;
  logic [31:0] jalrSum;
  logic [31:0] target;
  logic        misaligned;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .BrEq   (BrEq),
    .BrLT   (BrLT),
    .work   (work),
    .cond   (brCond)
  );

  // Target selection with jalr > jal > branch priority.
  always_comb begin
    jalrSum  = rs1_data + imm;
    redirReq = is_jalr | is_jal | (is_branch & brCond);
    target   = is_jalr ? {jalrSum[31:1], 1'b0} : (pcQ + imm);
    misaligned = (target[1:0] != 2'b00);
  end

  // Next-state logic; stall freezes everything and suppresses taken.
  always_comb begin
    stateD    = stateQ;
    pcD       = pcQ;
    flushD    = flushQ;
    trapD     = trapQ;
    trapAddrD = trapAddrQ;
    cntD      = cntQ;
    flushCntD = flushCntQ;
    taken     = 1'b0;
    if (!stall) begin
      unique case (stateQ)
        ST_RUN: begin
          if (instr_valid) begin
            if (redirReq && misaligned) begin
              trapD     = 1'b1;
              trapAddrD = target;
              stateD    = ST_TRAP;
            end else if (redirReq) begin
              taken     = 1'b1;
              pcD       = target;
              cntD      = cntQ + CNT_W'(1);
              flushD    = 1'b1;
              flushCntD = FCW'(FLUSH_LEN);
              stateD    = ST_FLUSH;
            end else begin
              pcD = pcQ + PC_STEP;
            end
          end
        end
        ST_FLUSH: begin
          pcD = pcQ + PC_STEP;
          if (flushCntQ == FCW'(1)) begin
            flushD    = 1'b0;
            flushCntD = '0;
            stateD    = ST_RUN;
          end else begin
            flushCntD = flushCntQ - FCW'(1);
          end
        end
        ST_TRAP: begin
          if (trap_clr) begin
            pcD    = TRAP_VEC;
            trapD  = 1'b0;
            stateD = ST_RUN;
          end
        end
        default: stateD = ST_RUN;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= ST_RUN;
      pcQ       <= RESET_PC;
      flushQ    <= 1'b0;
      trapQ     <= 1'b0;
      trapAddrQ <= '0;
      cntQ      <= '0;
      flushCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      pcQ       <= pcD;
      flushQ    <= flushD;
      trapQ     <= trapD;
      trapAddrQ <= trapAddrD;
      cntQ      <= cntD;
      flushCntQ <= flushCntD;
    end
  end

  assign pc        = pcQ;
  assign link_addr = pcQ + PC_STEP;
  assign flush     = flushQ;
  assign trap      = trapQ;
  assign trap_addr = trapAddrQ;
  assign taken_cnt = cntQ;

endmodule
